// File: rtl/gpio_poll_master.sv
// gpio_poll_master: an autonomous second bus master. Every POLL_PERIOD cycles
// it reads the switch word, XORs it with a mask, and writes the result to the
// LED word. It arbitrates for the bus with a simple req/gnt handshake.
module gpio_poll_master #(
  parameter int unsigned POLL_PERIOD = 50000,
  parameter logic [31:0] SRC_ADDR    = 32'h0000_7F60,
  parameter logic [31:0] DST_ADDR    = 32'h0000_7F70,
  parameter bit          CHANGE_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] xor_mask,
  input  logic        clr_overrun,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic [3:0]  m_we,
  input  logic [31:0] m_rd,
  output logic [31:0] last_value,
  output logic        done,
  output logic        overrun,
  output logic [15:0] xfer_count
);

  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TW-1:0] TC_VALUE = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          tc;
  logic [31:0]   masked;

  assign tc     = enable && (timer == TC_VALUE);
  assign masked = m_rd ^ xor_mask;

  // Byte enables follow the live grant so a stalled write never strobes; the
  // async reset forces the state to IDLE, which drops them immediately.
  assign m_we = ((state == S_WRITE) && bus_gnt) ? 4'hF : 4'h0;

  // Poll timer: free-runs 0..POLL_PERIOD-1 while enabled, parked at 0 otherwise.
  // NOTE: sequential state is updated with non-blocking (<=) assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!enable || tc) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Transaction FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bus_req    <= 1'b0;
      m_addr     <= '0;
      m_wd       <= '0;
      last_value <= '0;
      done       <= 1'b0;
      xfer_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tc) begin
            state   <= S_REQ;
            bus_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (!enable) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
          end else if (bus_gnt) begin
            state  <= S_READ;
            m_addr <= SRC_ADDR;
          end
        end
        S_READ: begin
          if (bus_gnt) begin
            last_value <= masked;
            if (CHANGE_ONLY && (masked == last_value)) begin
              // Nothing changed on the switches: finish without a write.
              state      <= S_DONE;
              bus_req    <= 1'b0;
              done       <= 1'b1;
              xfer_count <= xfer_count + 16'd1;
            end else begin
              state  <= S_WRITE;
              m_addr <= DST_ADDR;
              m_wd   <= masked;
            end
          end
        end
        S_WRITE: begin
          if (bus_gnt) begin
            state      <= S_DONE;
            bus_req    <= 1'b0;
            done       <= 1'b1;
            xfer_count <= xfer_count + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a poll came due while a transaction was in flight; set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (tc && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_poll_master.sv
// Directed testbench for gpio_poll_master with POLL_PERIOD=4.
// Inputs change and outputs are sampled 2-3 time units after each rising edge.
module tb_gpio_poll_master;

  localparam logic [31:0] SRC = 32'h0000_7F60;
  localparam logic [31:0] DST = 32'h0000_7F70;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] xor_mask;
  logic        clr_overrun;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_we;
  logic [31:0] m_rd;
  logic [31:0] last_value;
  logic        done;
  logic        overrun;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  gpio_poll_master #(
    .POLL_PERIOD(4),
    .SRC_ADDR(SRC),
    .DST_ADDR(DST),
    .CHANGE_ONLY(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .xor_mask(xor_mask),
    .clr_overrun(clr_overrun),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .m_addr(m_addr),
    .m_wd(m_wd),
    .m_we(m_we),
    .m_rd(m_rd),
    .last_value(last_value),
    .done(done),
    .overrun(overrun),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_we == 4'hF) we_cnt = we_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // From IDLE with timer at 0: enable now, REQ is reached 4 cycles later.
  task automatic start_poll();
    enable = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
    checks++; if (m_wd !== 32'h0) begin errors++; $display("FAIL rst_m_wd got=%h exp=0", m_wd); end
    checks++; if (m_we !== 4'h0) begin errors++; $display("FAIL rst_m_we got=%h exp=0", m_we); end
    checks++; if (last_value !== 32'h0) begin errors++; $display("FAIL rst_last_value got=%h exp=0", last_value); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%0h exp=0", overrun); end
    checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL rst_xfer_count got=%0d exp=0", xfer_count); end
  endtask

  // Reset is released in the current cycle; enable is already high.
  task automatic test_basic_poll();
    repeat (3) step();  // tc cycle, still idle
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL basic_tc_req got=%0h exp=0", bus_req); end
    step();             // REQ
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL basic_req got=%0h exp=1", bus_req); end
    step();             // READ
    checks++; if (m_addr !== SRC) begin errors++; $display("FAIL basic_rd_addr got=%h exp=%h", m_addr, SRC); end
    checks++; if (m_we !== 4'h0) begin errors++; $display("FAIL basic_rd_we got=%h exp=0", m_we); end
    enable = 1'b0;
    step();             // WRITE
    checks++; if (m_addr !== DST) begin errors++; $display("FAIL basic_wr_addr got=%h exp=%h", m_addr, DST); end
    checks++; if (m_wd !== 32'hA5) begin errors++; $display("FAIL basic_wr_data got=%h exp=a5", m_wd); end
    checks++; if (m_we !== 4'hF) begin errors++; $display("FAIL basic_wr_we got=%h exp=f", m_we); end
    step();             // DONE, 4 cycles after tc
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%0h exp=1", done); end
    checks++; if (xfer_count !== 16'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", xfer_count); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL basic_done_req got=%0h exp=0", bus_req); end
    checks++; if (last_value !== 32'hA5) begin errors++; $display("FAIL basic_last got=%h exp=a5", last_value); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%0h exp=0", done); end
  endtask

  task automatic test_change_only();
    int we0;
    we0 = we_cnt;
    start_poll();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL chg_req got=%0h exp=1", bus_req); end
    step();             // READ
    enable = 1'b0;
    step();             // straight to DONE
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL chg_done got=%0h exp=1", done); end
    checks++; if (m_we !== 4'h0) begin errors++; $display("FAIL chg_we got=%h exp=0", m_we); end
    checks++; if (xfer_count !== 16'd2) begin errors++; $display("FAIL chg_count got=%0d exp=2", xfer_count); end
    step(); step();
    checks++; if (we_cnt !== we0) begin errors++; $display("FAIL chg_no_write writes=%0d exp=0", we_cnt - we0); end
  endtask

  task automatic test_mask();
    xor_mask = 32'hFFFF_FFFF;
    m_rd     = 32'h0;
    start_poll();
    step();             // READ
    enable = 1'b0;
    step();             // WRITE
    checks++; if (m_wd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mask_wd got=%h exp=ffffffff", m_wd); end
    checks++; if (m_we !== 4'hF) begin errors++; $display("FAIL mask_we got=%h exp=f", m_we); end
    step();             // DONE
    checks++; if (last_value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mask_last got=%h exp=ffffffff", last_value); end
    checks++; if (xfer_count !== 16'd3) begin errors++; $display("FAIL mask_count got=%0d exp=3", xfer_count); end
    step();
  endtask

  task automatic test_write_stall();
    int we0;
    int d0;
    we0 = we_cnt;
    d0  = done_cnt;
    xor_mask = 32'h0;
    m_rd     = 32'h1234_5678;
    start_poll();
    step();             // READ
    enable = 1'b0;
    step();             // WRITE, grant withdrawn for 3 cycles
    bus_gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++; if (m_we !== 4'h0) begin errors++; $display("FAIL stall_we[%0d] got=%h exp=0", i, m_we); end
    end
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL stall_req got=%0h exp=1", bus_req); end
    step();
    bus_gnt = 1'b1;
    #1;
    checks++; if (m_we !== 4'hF) begin errors++; $display("FAIL stall_we_resume got=%h exp=f", m_we); end
    checks++; if (m_wd !== 32'h1234_5678) begin errors++; $display("FAIL stall_wd got=%h exp=12345678", m_wd); end
    step();             // DONE
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got=%0h exp=1", done); end
    checks++; if (xfer_count !== 16'd4) begin errors++; $display("FAIL stall_count got=%0d exp=4", xfer_count); end
    step(); step();
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL stall_writes got=%0d exp=1", we_cnt - we0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stall_dones got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_overrun();
    bus_gnt = 1'b0;
    start_poll();       // R: stuck in REQ, timer 0
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got=%0h exp=0", overrun); end
    repeat (4) step();  // R+4: tc happened while busy
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0h exp=1", overrun); end
    step(); step();     // R+6
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%0h exp=1", overrun); end
    clr_overrun = 1'b1;
    step();             // R+7
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%0h exp=0", overrun); end
    step();             // R+8, set again by tc at end of R+7
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_reset got=%0h exp=1", overrun); end
    repeat (3) step();  // R+11 is a tc cycle
    clr_overrun = 1'b1;
    step();             // R+12
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got=%0h exp=1", overrun); end
    clr_overrun = 1'b1;
    step();             // R+13
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear2 got=%0h exp=0", overrun); end
    enable  = 1'b0;     // abandon the REQ
    bus_gnt = 1'b1;
    step();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ovr_abort_req got=%0h exp=0", bus_req); end
    step();
    checks++; if (xfer_count !== 16'd4) begin errors++; $display("FAIL ovr_count got=%0d exp=4", xfer_count); end
  endtask

  task automatic test_reset_mid();
    m_rd = 32'h0000_0055;
    start_poll();
    step();             // READ
    checks++; if (m_addr !== SRC) begin errors++; $display("FAIL rmid_addr_pre got=%h exp=%h", m_addr, SRC); end
    #1;
    reset = 1'b1;
    #1;                 // well before the next edge
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%0h exp=0", bus_req); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", m_addr); end
    checks++; if (m_we !== 4'h0) begin errors++; $display("FAIL rmid_we got=%h exp=0", m_we); end
    checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", xfer_count); end
    step();
    reset = 1'b0;       // enable stays high
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmid_early_req[%0d] got=%0h exp=0", i, bus_req); end
    end
    step();             // REQ after a full period
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_req_after got=%0h exp=1", bus_req); end
    step();             // READ
    enable = 1'b0;
    step();             // WRITE
    checks++; if (m_wd !== 32'h55) begin errors++; $display("FAIL rmid_wd got=%h exp=55", m_wd); end
    step();             // DONE
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done got=%0h exp=1", done); end
    checks++; if (xfer_count !== 16'd1) begin errors++; $display("FAIL rmid_count_after got=%0d exp=1", xfer_count); end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    xor_mask    = 32'h0;
    clr_overrun = 1'b0;
    bus_gnt     = 1'b1;
    m_rd        = 32'h0;
    step(); step();
    test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    m_rd   = 32'h0000_00A5;
    test_basic_poll();
    test_change_only();
    test_mask();
    test_write_stall();
    test_overrun();
    test_reset_mid();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
